adc_sample_capture: RTL

Receive-side companion to the ADC SPI sequencer. Shifts the ADC's serial conversion result in on `sck` while the sequencer holds `reading` high, and assembles a parallel sample. It moves each completed sample into the system `clk` domain through a toggle synchronizer and buffers it in a small show-ahead FIFO for the downstream signal-processing logic.

---
 rtl/adc_sample_capture.sv | 120 ++++++++++++
 1 files changed

// File: rtl/adc_sample_capture.sv
// Captures serial ADC frames on sck, hands each finished sample to the clk domain
// through a toggle synchronizer and buffers it in a show-ahead FIFO.
module adc_sample_capture #(
   parameter int SAMPLE_BITS = 12,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sck,
   input  logic                   sdi,
   input  logic                   reading,
   input  logic                   rd_en,
   output logic [SAMPLE_BITS-1:0] rd_data,
   output logic                   rd_valid,
   output logic                   overflow,
   output logic [15:0]            sample_count
);

   localparam int CW = $clog2(SAMPLE_BITS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);

   // The oldest shifted bit falls off at frame completion, so only SAMPLE_BITS-1 are kept.
   logic [SAMPLE_BITS-2:0] shift_q;
   logic [SAMPLE_BITS-1:0] frame_d;
   logic [SAMPLE_BITS-1:0] hold_q;
   logic [CW-1:0]          bitCnt_q;
   logic                   sampleTgl_q;

   assign frame_d = {shift_q, sdi};

   always_ff @(posedge sck or negedge reset) begin
      if (!reset) begin
         shift_q     <= '0;
         hold_q      <= '0;
         bitCnt_q    <= '0;
         sampleTgl_q <= 1'b0;
      end else if (reading) begin
         shift_q <= frame_d[SAMPLE_BITS-2:0];
         if (bitCnt_q == LAST_BIT) begin
            hold_q      <= frame_d;
            sampleTgl_q <= ~sampleTgl_q;
            bitCnt_q    <= '0;
         end else begin
            bitCnt_q <= bitCnt_q + CW'(1);
         end
      end else begin
         bitCnt_q <= '0;
      end
   end

   logic sync1_q, sync2_q, sync3_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= sampleTgl_q;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   logic [SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]            wrPtr_q, wrPtr_d;
   logic [AW:0]            rdPtr_q, rdPtr_d;
   logic [15:0]            sampleCount_q, sampleCount_d;
   logic                   overflow_q, overflow_d;
   logic                   push, pop, full, accept;

   // hold_q is quiet for a whole frame around each toggle, so it is sampled here without resync.
   always_comb begin
      push          = sync2_q ^ sync3_q;
      full          = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
      pop           = rd_en && rd_valid;
      accept        = push && (!full || pop);
      wrPtr_d       = wrPtr_q;
      rdPtr_d       = rdPtr_q;
      sampleCount_d = sampleCount_q;
      overflow_d    = overflow_q;
      if (accept) begin
         wrPtr_d       = wrPtr_q + (AW+1)'(1);
         sampleCount_d = sampleCount_q + 16'd1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + (AW+1)'(1);
      end
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         sampleCount_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         if (accept) begin
            mem_q[wrPtr_q[AW-1:0]] <= hold_q;
         end
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         sampleCount_q <= sampleCount_d;
         overflow_q    <= overflow_d;
      end
   end

   assign rd_data      = mem_q[rdPtr_q[AW-1:0]];
   assign rd_valid     = (wrPtr_q != rdPtr_q);
   assign overflow     = overflow_q;
   assign sample_count = sampleCount_q;

endmodule
